// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared types and default constants for the I/O bridge.
// Holds the bridge FSM states and the latched master-side request bundle.
package io_bridge_pkg;

   localparam int IOBR_DWID = 32;
   localparam int IOBR_AWID = 32;

   localparam logic [IOBR_AWID-1:0] IOBR_IO_BASE = 32'hFD00_0000;
   localparam logic [IOBR_AWID-1:0] IOBR_IO_MASK = 32'hFF00_0000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_NACK = 2'd2,
      WR_POST   = 2'd3
   } state_e;

   typedef struct packed {
      logic                   we;
      logic [IOBR_DWID/8-1:0] sel;
      logic [IOBR_AWID-1:0]   adr;
      logic [IOBR_DWID-1:0]   dat;
   } io_req_t;

endpackage

// File: rtl/io_bridge_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1.
// The previously granted port has the lowest priority.
module rr_arbiter
   import io_bridge_pkg::*;
#(
   parameter int NPORT = 2,
   localparam int LW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic [NPORT-1:0] req_i,
   input  logic [LW-1:0]    last_i,
   input  logic             en_i,
   output logic             gnt_valid_o,
   output logic [LW-1:0]    gnt_idx_o
);

   // Walk from furthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int k = NPORT; k >= 1; k--) begin
         if (en_i && req_i[(int'(last_i) + k) % NPORT]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = LW'((int'(last_i) + k) % NPORT);
         end
      end
   end

endmodule

// File: rtl/io_bridge_arb.sv
// io_bridge_arb: N-port round-robin bridge onto the registered I/O bus.
// Define IOBR_POSTED_WR_EN to acknowledge writes at grant time (WR_POST).
module io_bridge_arb
   import io_bridge_pkg::*;
#(
   parameter int              NPORT     = 2,
   parameter int              DWID      = IOBR_DWID,
   parameter int              AWID      = IOBR_AWID,
   parameter logic [AWID-1:0] IO_BASE   = IOBR_IO_BASE,
   parameter logic [AWID-1:0] IO_MASK   = IOBR_IO_MASK,
   parameter int              TO_CYCLES = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           io_gate_en_i,
   input  logic [NPORT-1:0]               s_cyc_i,
   input  logic [NPORT-1:0]               s_stb_i,
   input  logic [NPORT-1:0]               s_we_i,
   input  logic [NPORT-1:0][DWID/8-1:0]   s_sel_i,
   input  logic [NPORT-1:0][AWID-1:0]     s_adr_i,
   input  logic [NPORT-1:0][DWID-1:0]     s_dat_i,
   output logic [NPORT-1:0]               s_ack_o,
   output logic [NPORT-1:0]               s_err_o,
   output logic [NPORT-1:0][DWID-1:0]     s_dat_o,
   output logic                           m_cyc_o,
   output logic                           m_stb_o,
   output logic                           m_we_o,
   output logic [DWID/8-1:0]              m_sel_o,
   output logic [AWID-1:0]                m_adr_o,
   output logic [DWID-1:0]                m_dat_o,
   input  logic                           m_ack_i,
   input  logic                           m_err_i,
   input  logic                           m_stall_i,
   input  logic [DWID-1:0]                m_dat_i
);

   localparam int         LW     = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);

   state_e           state_q, state_d;
   logic [LW-1:0]    gnt_q, gnt_d;
   logic [LW-1:0]    last_q, last_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             m_cyc_q, m_cyc_d;
   io_req_t          req_q, req_d;
   logic [NPORT-1:0] ack_q, ack_d;
   logic [NPORT-1:0] err_q, err_d;
   logic [DWID-1:0]  rdat_q, rdat_d;
`ifdef IOBR_POSTED_WR_EN
   logic             pdone_q, pdone_d;
   logic             werr_q, werr_d;
`endif

   logic [NPORT-1:0] req;
   logic             arb_vld;
   logic [LW-1:0]    arb_idx;
   logic [LW-1:0]    pidx;
   io_req_t          port_req;
   logic             tmo;

   always_comb begin
      req = '0;
      for (int i = 0; i < NPORT; i++) begin
         req[i] = s_cyc_i[i] & s_stb_i[i]
                & ((s_adr_i[i] & IO_MASK) == IO_BASE);
      end
   end

   rr_arbiter #(.NPORT(NPORT)) u_arb (
      .req_i       (req),
      .last_i      (last_q),
      .en_i        (io_gate_en_i & ~m_stall_i & ~m_ack_i),
      .gnt_valid_o (arb_vld),
      .gnt_idx_o   (arb_idx)
   );

   // In IDLE the winner is loaded; later the granted port re-drives RMW.
   always_comb begin
      pidx         = (state_q == IDLE) ? arb_idx : gnt_q;
      port_req.we  = s_we_i[pidx];
      port_req.sel = s_sel_i[pidx];
      port_req.adr = s_adr_i[pidx];
      port_req.dat = s_dat_i[pidx];
   end

   assign tmo = (TO_CYCLES != 0) && ((cnt_q + 8'd1) == TO_LIM);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      m_cyc_d = m_cyc_q;
      req_d   = req_q;
      ack_d   = ack_q;
      err_d   = err_q;
      rdat_d  = rdat_q;
`ifdef IOBR_POSTED_WR_EN
      pdone_d = pdone_q;
      werr_d  = werr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_vld) begin
               gnt_d   = arb_idx;
               req_d   = port_req;
               m_cyc_d = 1'b1;
               cnt_d   = '0;
               state_d = WAIT_ACK;
`ifdef IOBR_POSTED_WR_EN
               if (port_req.we) begin
                  ack_d[arb_idx] = 1'b1;
                  state_d        = WR_POST;
               end
`endif
            end
         end
         WAIT_ACK: begin
            if (m_ack_i) begin
               rdat_d       = m_dat_i;
               ack_d[gnt_q] = 1'b1;
               m_cyc_d      = 1'b0;
               req_d        = '0;
               state_d      = WAIT_NACK;
            end else if (m_err_i || tmo) begin
               err_d[gnt_q] = 1'b1;
               m_cyc_d      = 1'b0;
               req_d        = '0;
               state_d      = WAIT_NACK;
            end else if (!s_cyc_i[gnt_q]) begin
               m_cyc_d = 1'b0;
               req_d   = '0;
               rdat_d  = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WAIT_NACK: begin
            if (!s_stb_i[gnt_q]) begin
               ack_d  = '0;
               err_d  = '0;
               rdat_d = '0;
               last_d = gnt_q;
               if (s_cyc_i[gnt_q]) begin
                  req_d   = port_req;
                  m_cyc_d = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT_ACK;
               end else begin
                  state_d = IDLE;
               end
            end
         end
`ifdef IOBR_POSTED_WR_EN
         WR_POST: begin
            if (!pdone_q) begin
               if (m_ack_i || m_err_i || tmo) begin
                  m_cyc_d = 1'b0;
                  req_d   = '0;
                  pdone_d = 1'b1;
                  if (!m_ack_i) werr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            if (!s_stb_i[gnt_q]) ack_d[gnt_q] = 1'b0;
            if ((pdone_q || pdone_d) && !ack_d[gnt_q]) begin
               last_d  = gnt_q;
               pdone_d = 1'b0;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         m_cyc_q <= 1'b0;
         req_q   <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdat_q  <= '0;
`ifdef IOBR_POSTED_WR_EN
         pdone_q <= 1'b0;
         werr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         m_cyc_q <= m_cyc_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
`ifdef IOBR_POSTED_WR_EN
         pdone_q <= pdone_d;
         werr_q  <= werr_d;
`endif
      end
   end

   // Read data is zero whenever nothing is being held for the port.
   always_comb begin
      s_dat_o        = '0;
      s_dat_o[gnt_q] = rdat_q;
   end

   assign s_ack_o = ack_q;
   assign s_err_o = err_q;
   assign m_cyc_o = m_cyc_q;
   assign m_stb_o = m_cyc_q;
   assign m_we_o  = req_q.we;
   assign m_sel_o = req_q.sel;
   assign m_adr_o = req_q.adr;
   assign m_dat_o = req_q.dat;

endmodule

// File: tb/tb_io_bridge_arb.sv
// tb_io_bridge_arb: directed checks of windowing, round-robin, timeout,
// abort, reset and write paths of io_bridge_arb (2 ports, timeout 16).
module tb_io_bridge_arb;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             io_gate_en_i;
   logic [1:0]       s_cyc_i, s_stb_i, s_we_i;
   logic [1:0][3:0]  s_sel_i;
   logic [1:0][31:0] s_adr_i, s_dat_i;
   logic [1:0]       s_ack_o, s_err_o;
   logic [1:0][31:0] s_dat_o;
   logic             m_cyc_o, m_stb_o, m_we_o;
   logic [3:0]       m_sel_o;
   logic [31:0]      m_adr_o, m_dat_o;
   logic             m_ack_i, m_err_i, m_stall_i;
   logic [31:0]      m_dat_i;

   int checks = 0;
   int errors = 0;
   int exp_w;

   io_bridge_arb #(.NPORT(2), .TO_CYCLES(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .io_gate_en_i (io_gate_en_i),
      .s_cyc_i      (s_cyc_i),
      .s_stb_i      (s_stb_i),
      .s_we_i       (s_we_i),
      .s_sel_i      (s_sel_i),
      .s_adr_i      (s_adr_i),
      .s_dat_i      (s_dat_i),
      .s_ack_o      (s_ack_o),
      .s_err_o      (s_err_o),
      .s_dat_o      (s_dat_o),
      .m_cyc_o      (m_cyc_o),
      .m_stb_o      (m_stb_o),
      .m_we_o       (m_we_o),
      .m_sel_o      (m_sel_o),
      .m_adr_o      (m_adr_o),
      .m_dat_o      (m_dat_o),
      .m_ack_i      (m_ack_i),
      .m_err_i      (m_err_i),
      .m_stall_i    (m_stall_i),
      .m_dat_i      (m_dat_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic port(input int p, input logic on, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
      s_cyc_i[p] = on;
      s_stb_i[p] = on;
      s_we_i[p]  = we;
      s_sel_i[p] = 4'hF;
      s_adr_i[p] = adr;
      s_dat_i[p] = dat;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      io_gate_en_i = 1'b1;
      s_cyc_i = '0; s_stb_i = '0; s_we_i = '0;
      s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
      m_ack_i = 1'b0; m_err_i = 1'b0; m_stall_i = 1'b0;
      m_dat_i = '0;
      tick(); tick();
      chk("rst_cyc", 64'(m_cyc_o), 64'd0);
      chk("rst_stb", 64'(m_stb_o), 64'd0);
      chk("rst_ack", 64'(s_ack_o), 64'd0);
      chk("rst_err", 64'(s_err_o), 64'd0);
      chk("rst_sdat", 64'(s_dat_o), 64'd0);
      chk("rst_adr", 64'(m_adr_o), 64'd0);
      rst_i = 1'b0;

      // Single read, two wait states
      port(0, 1'b1, 1'b0, 32'hFD00_0010, 32'h0);
      tick();
      chk("rd_grant_cyc", 64'(m_cyc_o), 64'd1);
      chk("rd_grant_adr", 64'(m_adr_o), 64'hFD00_0010);
      chk("rd_grant_we", 64'(m_we_o), 64'd0);
      tick(); tick();
      chk("rd_wait_ack", 64'(s_ack_o), 64'd0);
      m_ack_i = 1'b1; m_dat_i = 32'hCAFE_BABE;
      tick();
      m_ack_i = 1'b0; m_dat_i = '0;
      chk("rd_ack", 64'(s_ack_o), 64'b01);
      chk("rd_dat", 64'(s_dat_o), 64'h0000_0000_CAFE_BABE);
      chk("rd_mcyc_clr", 64'(m_cyc_o), 64'd0);
      tick();
      chk("rd_hold_ack", 64'(s_ack_o), 64'b01);
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("rd_rel_ack", 64'(s_ack_o), 64'd0);
      chk("rd_rel_dat", 64'(s_dat_o), 64'd0);

      // Stray device ack while idle
      m_ack_i = 1'b1;
      tick();
      m_ack_i = 1'b0;
      chk("stray_ack", 64'(s_ack_o), 64'd0);

      // Window miss on port1, port0 still served
      port(1, 1'b1, 1'b0, 32'hFE00_0000, 32'h0);
      tick(); tick();
      chk("miss_cyc", 64'(m_cyc_o), 64'd0);
      chk("miss_ack", 64'(s_ack_o), 64'd0);
      port(0, 1'b1, 1'b0, 32'hFD00_0020, 32'h0);
      tick();
      chk("miss_p0_adr", 64'(m_adr_o), 64'hFD00_0020);
      m_ack_i = 1'b1; m_dat_i = 32'h0000_0055;
      tick();
      m_ack_i = 1'b0;
      chk("miss_p0_ack", 64'(s_ack_o), 64'b01);
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Contention: last grant was port0, so port1 goes first
      port(0, 1'b1, 1'b0, 32'hFD00_0100, 32'h0);
      port(1, 1'b1, 1'b0, 32'hFD00_0200, 32'h0);
      for (int k = 0; k < 4; k++) begin
         exp_w = (k % 2 == 0) ? 1 : 0;
         tick();
         chk("rr_adr", 64'(m_adr_o),
             (exp_w == 1) ? 64'hFD00_0200 : 64'hFD00_0100);
         m_ack_i = 1'b1; m_dat_i = 32'h100 + k;
         tick();
         m_ack_i = 1'b0;
         chk("rr_ack", 64'(s_ack_o), (exp_w == 1) ? 64'b10 : 64'b01);
         s_cyc_i[exp_w] = 1'b0; s_stb_i[exp_w] = 1'b0;
         tick();
         s_cyc_i[exp_w] = 1'b1; s_stb_i[exp_w] = 1'b1;
      end
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Timeout after 16 clocks in WAIT_ACK
      port(0, 1'b1, 1'b0, 32'hFD00_0030, 32'h0);
      tick();
      chk("to_grant", 64'(m_cyc_o), 64'd1);
      for (int k = 0; k < 15; k++) tick();
      chk("to_before_err", 64'(s_err_o), 64'd0);
      chk("to_before_cyc", 64'(m_cyc_o), 64'd1);
      tick();
      chk("to_err", 64'(s_err_o), 64'b01);
      chk("to_cyc_clr", 64'(m_cyc_o), 64'd0);
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("to_err_rel", 64'(s_err_o), 64'd0);
      port(0, 1'b1, 1'b0, 32'hFD00_0040, 32'h0);
      tick();
      chk("to_next_adr", 64'(m_adr_o), 64'hFD00_0040);
      m_ack_i = 1'b1; m_dat_i = 32'h0000_0AAA;
      tick();
      m_ack_i = 1'b0;
      chk("to_next_dat", 64'(s_dat_o), 64'h0000_0000_0000_0AAA);
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Abort by dropping cyc in WAIT_ACK
      port(0, 1'b1, 1'b0, 32'hFD00_0050, 32'h0);
      tick(); tick();
      port(0, 1'b0, 1'b0, 32'hFD00_0050, 32'h0);
      tick();
      chk("abort_cyc", 64'(m_cyc_o), 64'd0);
      chk("abort_ack", 64'(s_ack_o), 64'd0);

      // Gate low blocks a new grant
      io_gate_en_i = 1'b0;
      port(0, 1'b1, 1'b0, 32'hFD00_0060, 32'h0);
      tick();
      chk("gate_block", 64'(m_cyc_o), 64'd0);
      io_gate_en_i = 1'b1;
      tick();
      chk("gate_open", 64'(m_cyc_o), 64'd1);

      // Reset in the middle of the read
      tick();
      rst_i = 1'b1;
      tick();
      chk("midrst_cyc", 64'(m_cyc_o), 64'd0);
      chk("midrst_adr", 64'(m_adr_o), 64'd0);
      chk("midrst_ack", 64'(s_ack_o), 64'd0);
      rst_i = 1'b0;
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Write
      port(0, 1'b1, 1'b1, 32'hFD00_0004, 32'h1234_5678);
      tick();
      chk("wr_we", 64'(m_we_o), 64'd1);
      chk("wr_dat", 64'(m_dat_o), 64'h1234_5678);
`ifdef IOBR_POSTED_WR_EN
      chk("wr_early_ack", 64'(s_ack_o), 64'b01);
`else
      chk("wr_early_ack", 64'(s_ack_o), 64'b00);
`endif
      m_ack_i = 1'b1;
      tick();
      m_ack_i = 1'b0;
      chk("wr_ack", 64'(s_ack_o), 64'b01);
      chk("wr_cyc_clr", 64'(m_cyc_o), 64'd0);
      port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("wr_rel_ack", 64'(s_ack_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
